// File: rtl/ddr_port1_reader.sv
// ddr_port1_reader
// Display-side read engine for a double-buffered DDR frame store. Each frame it
// reads the buffer that the port-0 writer is not filling, using MCB port 1, and
// holds the data in a local pixel FIFO that the VGA timing stage pops on demand.
// Commands are credit-limited: a burst is only requested when the FIFO is sure to
// have room for it, so returning data never has to be throttled.
//
// Optional build macro DDR_RD_TESTPATTERN_EN: when defined, each FIFO entry is a
// per-frame running count of received words instead of the MCB read data. This
// lets bandwidth and underflow be exercised without real frame contents.
module ddr_port1_reader #(
    parameter int BURST_LEN   = 32,
    parameter int FRAME_WORDS = 1310720,
    parameter int FIFO_DEPTH  = 128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_calib_done,
    input  logic        memory_frame,
    input  logic        frame_start,
    input  logic        pixel_rd,
    output logic [23:0] pixel,
    output logic        pixel_valid,
    output logic        underflow,
    output logic        p1_cmd_en,
    output logic [2:0]  p1_cmd_instr,
    output logic [5:0]  p1_cmd_bl,
    output logic [29:0] p1_cmd_byte_addr,
    input  logic        p1_cmd_full,
    output logic        p1_rd_en,
    input  logic [31:0] p1_rd_data,
    input  logic        p1_rd_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_FRAME = 3'd1;
    localparam logic [2:0] ST_REQ        = 3'd2;
    localparam logic [2:0] ST_ISSUE      = 3'd3;
    localparam logic [2:0] ST_FLUSH      = 3'd4;

    // Byte address of the second frame buffer.
    localparam logic [29:0] BUF1_BASE = 30'd5242880;

    // MCB read command encoding.
    localparam logic [2:0] INSTR_READ = 3'b001;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic        r_calib_meta;
    logic        r_calib_sync;
    logic [2:0]  r_state;
    logic [29:0] r_base;
    logic [21:0] r_word_idx;
    logic [7:0]  r_outstanding;
    logic        r_underflow;

    logic        r_cmd_en;
    logic [2:0]  r_cmd_instr;
    logic [5:0]  r_cmd_bl;
    logic [29:0] r_cmd_addr;

    logic [23:0]   r_fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_fifo_count;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic        w_rd_pop;
    logic        w_fifo_push;
    logic        w_fifo_pop;
    logic        w_fifo_empty;
    logic        w_flush_done;
    logic        w_frame_accept;
    logic        w_new_frame;
    logic        w_issue;
    logic        w_more_words;
    logic        w_frame_done;
    logic        w_credit_ok;
    logic [31:0] w_credit_sum;
    logic [29:0] w_frame_base;
    logic [29:0] w_cmd_addr;
    logic [23:0] w_fifo_wdata;

    // Data is drained from the MCB whenever words are owed to us, in every
    // state; during a flush the popped words are simply not stored.
    assign w_rd_pop     = !p1_rd_empty && (r_outstanding != 8'd0);
    assign w_fifo_push  = w_rd_pop && (r_state != ST_FLUSH);
    assign w_fifo_empty = (r_fifo_count == '0);
    assign w_fifo_pop   = pixel_rd && !w_fifo_empty;

    // A flush ends once every owed word has been discarded.
    assign w_flush_done   = (r_state == ST_FLUSH) && (r_outstanding == 8'd0);
    assign w_frame_accept = frame_start &&
                            ((r_state == ST_WAIT_FRAME) || (r_state == ST_REQ) ||
                             (r_state == ST_ISSUE));
    // Per-frame bookkeeping restarts on a clean frame start or at flush exit.
    assign w_new_frame  = ((r_state == ST_WAIT_FRAME) && frame_start) || w_flush_done;
    assign w_issue      = (r_state == ST_ISSUE);

    assign w_more_words = ({10'd0, r_word_idx} < 32'(FRAME_WORDS));
    assign w_frame_done = ({10'd0, r_word_idx} == 32'(FRAME_WORDS));

    // Words already buffered plus words still owed plus the new burst must fit.
    assign w_credit_sum = 32'(r_fifo_count) + 32'(r_outstanding) + 32'(BURST_LEN);
    assign w_credit_ok  = (w_credit_sum <= 32'(FIFO_DEPTH));

    assign w_frame_base = memory_frame ? BUF1_BASE : 30'd0;
    assign w_cmd_addr   = r_base + {6'd0, r_word_idx, 2'b00};

`ifdef DDR_RD_TESTPATTERN_EN
    logic [23:0] r_word_idx_rx;
    logic        w_unused_data;

    assign w_fifo_wdata  = r_word_idx_rx;
    assign w_unused_data = &{1'b0, p1_rd_data};

    // Running count of words stored this frame, used as the pixel value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word_idx_rx <= 24'd0;
        end else if (w_new_frame) begin
            r_word_idx_rx <= 24'd0;
        end else if (w_fifo_push) begin
            r_word_idx_rx <= r_word_idx_rx + 24'd1;
        end
    end
`else
    logic [7:0] w_unused_data;

    assign w_fifo_wdata  = p1_rd_data[23:0];
    assign w_unused_data = p1_rd_data[31:24];
`endif

    // ------------------------------------------------------------------
    // Calibration-done synchroniser (asynchronous source)
    // ------------------------------------------------------------------
    // Two-flop synchroniser for the MCB calibration flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_calib_meta <= 1'b0;
            r_calib_sync <= 1'b0;
        end else begin
            r_calib_meta <= mem_calib_done;
            r_calib_sync <= r_calib_meta;
        end
    end

    // ------------------------------------------------------------------
    // Main FSM: frame sequencing and command generation
    // ------------------------------------------------------------------
    // Walks the frame in bursts; the command fields are registered so the MCB
    // sees a clean one-cycle command in the ISSUE state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_base      <= 30'd0;
            r_word_idx  <= 22'd0;
            r_cmd_en    <= 1'b0;
            r_cmd_instr <= 3'd0;
            r_cmd_bl    <= 6'd0;
            r_cmd_addr  <= 30'd0;
        end else begin
            r_cmd_en <= 1'b0;
            // The new buffer is chosen only when a frame start is accepted.
            if (w_frame_accept) begin
                r_base <= w_frame_base;
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_calib_sync) begin
                        r_state <= ST_WAIT_FRAME;
                    end
                end
                ST_WAIT_FRAME: begin
                    if (frame_start) begin
                        r_word_idx <= 22'd0;
                        r_state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (frame_start) begin
                        r_state <= ST_FLUSH;
                    end else if (w_more_words && !p1_cmd_full && w_credit_ok) begin
                        r_cmd_en    <= 1'b1;
                        r_cmd_instr <= INSTR_READ;
                        r_cmd_bl    <= 6'(BURST_LEN - 1);
                        r_cmd_addr  <= w_cmd_addr;
                        r_state     <= ST_ISSUE;
                    end else if (w_frame_done && (r_outstanding == 8'd0)) begin
                        r_state <= ST_WAIT_FRAME;
                    end
                end
                ST_ISSUE: begin
                    // The command goes out this cycle regardless of a restart,
                    // so its words are still accounted for and later discarded.
                    r_word_idx <= r_word_idx + 22'(BURST_LEN);
                    if (frame_start) begin
                        r_state <= ST_FLUSH;
                    end else begin
                        r_state <= ST_REQ;
                    end
                end
                ST_FLUSH: begin
                    if (r_outstanding == 8'd0) begin
                        r_word_idx <= 22'd0;
                        r_state    <= ST_REQ;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outstanding-word credit counter
    // ------------------------------------------------------------------
    // Counts words requested from the MCB but not yet popped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_outstanding <= 8'd0;
        end else if ((r_state == ST_WAIT_FRAME) && frame_start) begin
            r_outstanding <= 8'd0;
        end else begin
            r_outstanding <= r_outstanding
                           + (w_issue  ? 8'(BURST_LEN) : 8'd0)
                           - (w_rd_pop ? 8'd1          : 8'd0);
        end
    end

    // ------------------------------------------------------------------
    // Underflow flag
    // ------------------------------------------------------------------
    // Sticky record of a display read against an empty FIFO, cleared per frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_underflow <= 1'b0;
        end else if (w_new_frame) begin
            r_underflow <= 1'b0;
        end else if (pixel_rd && w_fifo_empty) begin
            r_underflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Local pixel FIFO
    // ------------------------------------------------------------------
    // Storage array; the head is read asynchronously so a word written into an
    // empty FIFO is visible on the very next cycle.
    always_ff @(posedge clk) begin
        if (w_fifo_push) begin
            r_fifo_mem[r_wr_ptr] <= w_fifo_wdata;
        end
    end

    // Pointers and occupancy; a flush exit discards everything still buffered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else if (w_flush_done) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_fifo_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_fifo_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_fifo_push, w_fifo_pop})
                2'b10:   r_fifo_count <= r_fifo_count + 1'b1;
                2'b01:   r_fifo_count <= r_fifo_count - 1'b1;
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pixel            = w_fifo_empty ? 24'd0 : r_fifo_mem[r_rd_ptr];
    assign pixel_valid      = !w_fifo_empty;
    assign underflow        = r_underflow;
    assign p1_cmd_en        = r_cmd_en;
    assign p1_cmd_instr     = r_cmd_instr;
    assign p1_cmd_bl        = r_cmd_bl;
    assign p1_cmd_byte_addr = r_cmd_addr;
    assign p1_rd_en         = w_rd_pop;

endmodule

// File: doc/ddr_port1_reader.md
# ddr_port1_reader

Display-side read engine for the double-buffered DDR frame store. Each frame it streams the buffer the port-0 writer is *not* currently filling from MCB port 1 into a local pixel FIFO. It presents 24-bit colour pixels to the VGA timing stage on demand. It tracks `memory_frame` from the writer so reads never touch the buffer being written.

## Interface
- `BURST_LEN`, 32: words per read command (1..64).
- `FRAME_WORDS`, 1310720: 32-bit words per frame; must be a multiple of `BURST_LEN`.
- `FIFO_DEPTH`, 128: local pixel FIFO depth in words (power of 2, ≥ 2·`BURST_LEN`).
- `clk` in 1: system clock, same domain as MCB port 1.
- `reset_n` in 1: asynchronous, active-low reset.
- `mem_calib_done` in 1: MCB calibration complete (asynchronous; synchronised internally with 2 flops).
- `memory_frame` in 1: writer's buffer select. Reader base = `memory_frame ? 0 : 30'd5242880`... inverted, i.e. reader base = `memory_frame ? 30'd5242880 : 0`.
- `frame_start` in 1: one-cycle pulse from display timing at vertical blank.
- `pixel_rd` in 1: display consumes the current pixel.
- `pixel` out 24: FIFO head `[23:0]`; 0 when empty.
- `pixel_valid` out 1: FIFO non-empty.
- `underflow` out 1: sticky; `pixel_rd` was seen while the FIFO was empty.
- `p1_cmd_en` out 1, `p1_cmd_instr` out 3, `p1_cmd_bl` out 6, `p1_cmd_byte_addr` out 30: MCB command port.
- `p1_cmd_full` in 1: MCB command FIFO full.
- `p1_rd_en` out 1: MCB read-data pop.
- `p1_rd_data` in 32: MCB read data, valid in the same cycle as `p1_rd_en`.
- `p1_rd_empty` in 1: MCB read FIFO empty.

## Operation
- States:
  - `IDLE`: wait for synced calib. Then go to `WAIT_FRAME`.
  - `WAIT_FRAME`: on `frame_start`, latch the base from `memory_frame`, clear `word_idx`, `outstanding` and `underflow`. Go to `REQ`.
  - `REQ`: if `word_idx < FRAME_WORDS` and `!p1_cmd_full` and `fifo_count + outstanding + BURST_LEN <= FIFO_DEPTH`, go to `ISSUE`.
    - If `word_idx == FRAME_WORDS` and `outstanding == 0`, go to `WAIT_FRAME`.
  - `ISSUE`: assert `p1_cmd_en` for one cycle with:
    - `p1_cmd_instr = 3'b001`
    - `p1_cmd_bl = BURST_LEN-1`
    - `p1_cmd_byte_addr = base + (word_idx << 2)`
    - `word_idx += BURST_LEN`
    - `outstanding += BURST_LEN`
    - Return to `REQ`.
  - `FLUSH`: entered on `frame_start` while in `REQ` or `ISSUE`. No new commands are issued. Arriving words are popped and discarded until `outstanding == 0`. Then the local FIFO is cleared and the new-frame actions of `WAIT_FRAME` are performed, and the block goes to `REQ`.
- Read drain runs concurrently with `REQ` and `ISSUE`:
  - `p1_rd_en = !p1_rd_empty && outstanding != 0` (combinational).
  - Each pop decrements `outstanding` and writes `p1_rd_data` into the FIFO; in `FLUSH` the word is discarded instead.
  - The credit rule guarantees space in the FIFO.
- Pop side:
  - `pixel_rd && pixel_valid` advances the FIFO head.
  - `pixel_rd && !pixel_valid` sets `underflow` and changes nothing else.
- Simultaneous FIFO push and pop in the same cycle: `fifo_count` is unchanged.
- `outstanding` is 8 bits and `word_idx` is 22 bits. Address arithmetic is 30-bit with no wrap.

## Timing
- Reset values: every output is 0, state is `IDLE`, and the FIFO is empty. The reset is asynchronous and may assert mid-burst. Data still held by the MCB after reset is not the block's concern; the MCB is reset alongside.
- Command latency: the cycle after `REQ` sees its conditions met, `p1_cmd_en` is high for exactly one cycle. Minimum spacing between commands is 2 cycles.
- Data latency: a popped word appears on `pixel` 1 cycle after `p1_rd_en` if the FIFO was empty. `pixel_valid` rises in the same cycle.
- `frame_start` in `WAIT_FRAME` takes effect the next cycle. In `FLUSH` a further `frame_start` is ignored.
- `memory_frame` is sampled only on accepted `frame_start`. Changes mid-frame do not move the base.

## Configuration
- `DDR_RD_TESTPATTERN_EN`:
  - Defined: the value written into the FIFO is `{8'd0, word_idx_rx[23:0]}`, a running count of received words that resets per frame, in place of `p1_rd_data`. All commands and handshakes are unchanged, so bandwidth and underflow can be tested without valid frame contents.
  - Undefined: the FIFO stores `p1_rd_data`.

## Test plan
- Calibration: `reset_n` low→high with `mem_calib_done=0` for 50 cycles → no `p1_cmd_en`. Calib=1 with no `frame_start` → still none.
- Base select:
  - `memory_frame=1`, `frame_start` → first command has addr 5242880, bl 31, instr 001.
  - Second command has addr 5242880+128.
  - With `memory_frame=0`, the first command has addr 0.
- Credit: `BURST_LEN=32`, `FIFO_DEPTH=128`, no `pixel_rd`, MCB returns data immediately → exactly 4 commands issued, then stall. One `pixel_rd` ×32 → a 5th command follows.
- Frame end: `FRAME_WORDS=64`, display drains continuously → exactly 2 commands, then `WAIT_FRAME`. No further `p1_cmd_en` until the next `frame_start`.
- Mid-frame restart:
  - `frame_start` while 32 words are outstanding → no commands until all 32 are popped.
  - The FIFO empties, `pixel_valid=0`, then a new command is issued at the new base offset 0.
- Underflow: `pixel_rd` with an empty FIFO → `underflow=1`, `pixel=0`. `underflow` stays set until the next `frame_start`.
